// File: rtl/mult_scheduler_if.sv
// Bus bundle for mult_scheduler: two requesters, the shared 4x4 multiplier
// link and the response channel. The scheduler uses the slave modport; the
// environment (requesters, multiplier, response consumer) uses master.
interface mult_scheduler_if;
    // Requester 0
    logic        req0_valid;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req0_ready;
    // Requester 1
    logic        req1_valid;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        req1_ready;
    // Shared external combinational 4x4 multiplier
    logic [3:0]  mul_m;
    logic [3:0]  mul_q;
    logic [7:0]  mul_p;
    // Response channel
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready;
    // Status
    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  mul_p,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output mul_m, mul_q,
        output rsp_valid, rsp_data, rsp_id,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output mul_p,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  mul_m, mul_q,
        input  rsp_valid, rsp_data, rsp_id,
        input  busy
    );
endinterface

// File: rtl/mult_scheduler.sv
// mult_scheduler: arbitrates two requesters onto one shared external 4x4
// combinational multiplier and builds the 8x8 product from four nibble
// partial products over four MUL cycles.
//
// Optional feature: define MULT_SCHED_RR_EN for round-robin arbitration on
// ties; otherwise req0 has fixed priority and no pointer register exists.
//
// Timing: accept edge E0, MUL steps on E1..E4, DONE entered on E4, response
// registered on E5 and held until rsp_ready is sampled high.
module mult_scheduler (
    input  logic                clk,
    input  logic                rst,
    mult_scheduler_if.slave     bus_io
);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    state_e      state_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic        id_q;
    logic [15:0] acc_q;
    logic [1:0]  step_q;
    logic [3:0]  mul_m_q;
    logic [3:0]  mul_q_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_data_q;
    logic        rsp_id_q;
`ifdef MULT_SCHED_RR_EN
    // 1: req1 preferred on the next tie (req0 was served last)
    logic        pref_q;
`endif

    logic        grant;
    logic        ready0;
    logic        ready1;
    logic        accept;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [15:0] partial;
    logic [15:0] acc_sum;
    logic [3:0]  next_m;
    logic [3:0]  next_q;

    // Grant selection from the current valids; a lone valid always wins.
    always_comb begin
`ifdef MULT_SCHED_RR_EN
        grant = bus_io.req0_valid ? (bus_io.req1_valid & pref_q) : 1'b1;
`else
        grant = ~bus_io.req0_valid;
`endif
    end

    // Ready only in IDLE, only to the granted side, never during reset.
    always_comb begin
        ready0 = (state_q == StIdle) && !rst && (grant == 1'b0);
        ready1 = (state_q == StIdle) && !rst && (grant == 1'b1);
        accept = grant ? (bus_io.req1_valid && ready1) : (bus_io.req0_valid && ready0);
        sel_a  = grant ? bus_io.req1_a : bus_io.req0_a;
        sel_b  = grant ? bus_io.req1_b : bus_io.req0_b;
    end

    // Align the current partial product and pick the operand nibbles for the
    // following step (zero after the last step so the multiplier idles at 0).
    always_comb begin
        partial = 16'd0;
        next_m  = 4'd0;
        next_q  = 4'd0;
        unique case (step_q)
            2'd0: begin
                partial = {8'd0, bus_io.mul_p};
                next_m  = a_q[7:4];
                next_q  = b_q[3:0];
            end
            2'd1: begin
                partial = {4'd0, bus_io.mul_p, 4'd0};
                next_m  = a_q[3:0];
                next_q  = b_q[7:4];
            end
            2'd2: begin
                partial = {4'd0, bus_io.mul_p, 4'd0};
                next_m  = a_q[7:4];
                next_q  = b_q[7:4];
            end
            2'd3: begin
                partial = {bus_io.mul_p, 8'd0};
                next_m  = 4'd0;
                next_q  = 4'd0;
            end
            default: begin
                partial = 16'd0;
            end
        endcase
        acc_sum = acc_q + partial;
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            id_q        <= 1'b0;
            acc_q       <= 16'd0;
            step_q      <= 2'd0;
            mul_m_q     <= 4'd0;
            mul_q_q     <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_id_q    <= 1'b0;
`ifdef MULT_SCHED_RR_EN
            pref_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        id_q    <= grant;
                        acc_q   <= 16'd0;
                        step_q  <= 2'd0;
                        // Step-0 operands are presented as soon as MUL starts
                        mul_m_q <= sel_a[3:0];
                        mul_q_q <= sel_b[3:0];
                        state_q <= StMul;
`ifdef MULT_SCHED_RR_EN
                        pref_q  <= ~grant;
`endif
                    end
                end
                StMul: begin
                    acc_q   <= acc_sum;
                    mul_m_q <= next_m;
                    mul_q_q <= next_q;
                    step_q  <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // First DONE cycle publishes the result; it then holds
                    // until the consumer takes it.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= acc_q;
                        rsp_id_q    <= id_q;
                    end else if (bus_io.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.req0_ready = ready0;
    assign bus_io.req1_ready = ready1;
    assign bus_io.mul_m      = mul_m_q;
    assign bus_io.mul_q      = mul_q_q;
    assign bus_io.rsp_valid  = rsp_valid_q;
    assign bus_io.rsp_data   = rsp_data_q;
    assign bus_io.rsp_id     = rsp_id_q;
    assign bus_io.busy       = (state_q != StIdle);

`ifndef SYNTHESIS
    ready_onehot_a: assert property (@(posedge clk) disable iff (rst) !(ready0 && ready1));
    mul_quiet_a: assert property (@(posedge clk) disable iff (rst)
        (state_q != StMul) |-> (mul_m_q == 4'd0 && mul_q_q == 4'd0));
`endif

endmodule

// File: tb/tb_mult_scheduler.sv
// Scoreboard bench for mult_scheduler. Expected products are hand-computed
// constants attached to each request and pushed when the bench's own
// arbitration model predicts an accept; a monitor pops and compares.
module tb_mult_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_scheduler_if bus ();

    // Shared external combinational multiplier
    assign bus.mul_p = bus.mul_m * bus.mul_q;

    mult_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct {
        logic [15:0] data;
        logic        id;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic [15:0] exp0, exp1;
    logic        m_busy   = 1'b0;
    logic        m_pref   = 1'b0;
    int          acc0_cnt = 0;
    int          acc1_cnt = 0;
    logic        rand_rdy_en = 1'b0;
    logic        rdy_force   = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Response-ready driver: random or forced level, changed just after posedge
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = rand_rdy_en ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: arbitration/busy model, response checks, scoreboard push/pop
    initial begin
        logic        e0, e1;
        logic        prev_v, prev_rdy, prev_id;
        logic [15:0] prev_data;
        exp_t        e;
        prev_v = 1'b0; prev_rdy = 1'b0; prev_id = 1'b0; prev_data = 16'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (m_busy) begin
                    e0 = 1'b0; e1 = 1'b0;
                end else if (bus.req0_valid && bus.req1_valid) begin
                    e0 = !m_pref; e1 = m_pref;
                end else begin
                    e0 = bus.req0_valid; e1 = bus.req1_valid;
                end
                if (m_busy) begin
                    chk("ready0_busy", bus.req0_ready, 0);
                    chk("ready1_busy", bus.req1_ready, 0);
                end else begin
                    if (bus.req0_valid) chk("ready0_grant", bus.req0_ready, e0);
                    if (bus.req1_valid) chk("ready1_grant", bus.req1_ready, e1);
                    chk("idle_quiet", {bus.rsp_valid, bus.mul_m, bus.mul_q}, 0);
                end
                chk("busy", bus.busy, m_busy);

                if (bus.rsp_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp actual=%0h required=none", bus.rsp_data);
                    end else begin
                        if (!prev_v) chk("latency", cyc - sb_q[0].acc_cyc, 6);
                        if (prev_v && !prev_rdy) begin
                            chk("hold_data", bus.rsp_data, prev_data);
                            chk("hold_id", bus.rsp_id, prev_id);
                        end
                        if (bus.rsp_ready) begin
                            e = sb_q.pop_front();
                            chk("rsp_data", bus.rsp_data, e.data);
                            chk("rsp_id", bus.rsp_id, e.id);
                            m_busy = 1'b0;
                        end
                    end
                end
                prev_v    = bus.rsp_valid;
                prev_rdy  = bus.rsp_ready;
                prev_data = bus.rsp_data;
                prev_id   = bus.rsp_id;

                if (bus.req0_valid && e0) begin
                    sb_q.push_back('{data: exp0, id: 1'b0, acc_cyc: cyc});
                    m_busy = 1'b1;
`ifdef MULT_SCHED_RR_EN
                    m_pref = 1'b1;
`endif
                    acc0_cnt++;
                end else if (bus.req1_valid && e1) begin
                    sb_q.push_back('{data: exp1, id: 1'b1, acc_cyc: cyc});
                    m_busy = 1'b1;
                    m_pref = 1'b0;
                    acc1_cnt++;
                end
            end
        end
    end

    task automatic set_req(input bit id, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] e);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; exp1 = e;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; exp0 = e;
        end
    endtask

    // Wait for the accept edge of requester id; optionally drop its valid.
    task automatic wait_accept(input bit id, input bit drop);
        int start;
        int n;
        start = id ? acc1_cnt : acc0_cnt;
        n = 0;
        while ((id ? acc1_cnt : acc0_cnt) == start && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk(id ? "accept1" : "accept0", (n < 200), 1);
        #1;
        if (drop) begin
            if (id) bus.req1_valid = 1'b0;
            else    bus.req0_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || m_busy) && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("drain", (n < 400), 1);
        #1;
    endtask

    typedef struct {
        bit          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        vecs[0] = '{1'b0, 8'h01, 8'h01, 16'h0001};
        vecs[1] = '{1'b1, 8'h10, 8'h10, 16'h0100};
        vecs[2] = '{1'b0, 8'hF0, 8'h0F, 16'h0E10};
        vecs[3] = '{1'b1, 8'h37, 8'h59, 16'h131F};
        vecs[4] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
        vecs[5] = '{1'b1, 8'h9C, 8'hE3, 16'h8A54};
        vecs[6] = '{1'b0, 8'hAB, 8'hCD, 16'h88EF};
        vecs[7] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01};

        bus.req0_valid = 1'b0; bus.req0_a = 8'd0; bus.req0_b = 8'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 8'd0; bus.req1_b = 8'd0;
        exp0 = 16'd0; exp1 = 16'd0;

        // Reset state, with both requesters already valid
        repeat (2) @(posedge clk);
        #1;
        set_req(0, 8'h12, 8'h34, 16'h03A8);
        set_req(1, 8'hAB, 8'hCD, 16'h88EF);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_mul", {bus.mul_m, bus.mul_q}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Tie at reset release
`ifdef MULT_SCHED_RR_EN
        wait_accept(0, 1);
        wait_accept(1, 1);
`else
        wait_accept(0, 0);
        wait_accept(0, 1);
        wait_accept(1, 1);
`endif
        drain();

        // Max operands
        set_req(0, 8'hFF, 8'hFF, 16'hFE01);
        wait_accept(0, 1);
        drain();

        // Consumer stalls for 10 cycles on a zero product
        rdy_force = 1'b0;
        set_req(1, 8'h00, 8'h5A, 16'h0000);
        wait_accept(1, 1);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("stall_rsp_seen", (n < 20), 1);
        repeat (10) @(posedge clk);
        rdy_force = 1'b1;
        drain();

        // Reset in MUL step 2 aborts the operation
        set_req(0, 8'h80, 8'h80, 16'h4000);
        wait_accept(0, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("step2_mul_m", bus.mul_m, 4'h0);
        chk("step2_mul_q", bus.mul_q, 4'h8);
        rst = 1'b1;
        sb_q.delete();
        m_busy = 1'b0;
        m_pref = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_rsp_data", bus.rsp_data, 0);
        chk("abort_mul", {bus.mul_m, bus.mul_q}, 0);
        chk("abort_ready", {bus.req0_ready, bus.req1_ready}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        set_req(0, 8'h0F, 8'h0F, 16'h00E1);
        set_req(1, 8'hFF, 8'h01, 16'h00FF);
        wait_accept(0, 1);
        wait_accept(1, 1);
        drain();

        // Directed table with a randomly stalling consumer
        rand_rdy_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p);
                wait_accept(vecs[i].id, 1);
            end
        end
        rand_rdy_en = 1'b0;
        repeat (2) @(posedge clk);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
